// File: rtl/meta_write_scheduler.sv
// Round-robin scheduler for L1 metadata writes from two requesters onto the tag-array
// write port, through a 2-entry FIFO with read-port deferral and a bounded-stall force.
module meta_write_scheduler #(
  parameter int IDX_W     = 6,
  parameter int WAYS      = 4,
  parameter int TAG_W     = 20,
  parameter int COH_W     = 2,
  parameter int STALL_MAX = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [IDX_W-1:0] in0_idx,
  input  logic [WAYS-1:0]  in0_way_en,
  input  logic [TAG_W-1:0] in0_tag,
  input  logic [COH_W-1:0] in0_coh,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [IDX_W-1:0] in1_idx,
  input  logic [WAYS-1:0]  in1_way_en,
  input  logic [TAG_W-1:0] in1_tag,
  input  logic [COH_W-1:0] in1_coh,
  input  logic             rd_busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [WAYS-1:0]  out_way_en,
  output logic [TAG_W-1:0] out_tag,
  output logic [COH_W-1:0] out_coh,
  output logic             out_src,
  output logic             force_wr,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_hit
);

  localparam logic [3:0] STALL_LIM = 4'(STALL_MAX);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WAYS-1:0]  way_en;
    logic [TAG_W-1:0] tag;
    logic [COH_W-1:0] coh;
    logic             src;
  } entry_t;

  entry_t     mem [2];
  logic       head, tail, rr_ptr;
  logic [1:0] count;
  logic [3:0] scnt;

  logic   space, grant0, grant1, accept, fire, scnt_inc;
  logic   valid0, valid1;
  entry_t push_e, head_e;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    space  = (count != 2'd2);
    grant0 = in0_valid & (~in1_valid | ~rr_ptr);
    grant1 = in1_valid & (~in0_valid | rr_ptr);
    // Ready is masked by reset because space is true while the FIFO is held empty.
    in0_ready = reset & space & grant0;
    in1_ready = reset & space & grant1;
    accept    = in0_ready | in1_ready;

    push_e = '{idx: in0_idx, way_en: in0_way_en, tag: in0_tag, coh: in0_coh, src: 1'b0};
    if (grant1) begin
      push_e = '{idx: in1_idx, way_en: in1_way_en, tag: in1_tag, coh: in1_coh, src: 1'b1};
    end

    head_e     = mem[head];
    out_idx    = head_e.idx;
    out_way_en = head_e.way_en;
    out_tag    = head_e.tag;
    out_coh    = head_e.coh;
    out_src    = head_e.src;

    out_valid = (count != 2'd0) & (~rd_busy | force_wr);
    fire      = out_valid & out_ready;
    scnt_inc  = (count != 2'd0) & rd_busy & ~force_wr;

    valid0     = (count == 2'd2) | ((count == 2'd1) & (head == 1'b0));
    valid1     = (count == 2'd2) | ((count == 2'd1) & (head == 1'b1));
    lookup_hit = (valid0 & (mem[0].idx == lookup_idx)) |
                 (valid1 & (mem[1].idx == lookup_idx));
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the two entry registers are reset so out_* read zero while in reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      count  <= 2'd0;
      rr_ptr <= 1'b0;
    end else begin
      if (accept) begin
        mem[tail] <= push_e;
        tail      <= ~tail;
        rr_ptr    <= in0_ready;  // after granting k, the other requester has priority
      end
      if (fire) head <= ~head;
      case ({accept, fire})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // force_wr rises together with scnt reaching the limit and holds until the write fires.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scnt     <= 4'd0;
      force_wr <= 1'b0;
    end else begin
      if (fire || count == 2'd0) scnt <= 4'd0;
      else if (scnt_inc)         scnt <= scnt + 4'd1;

      if (fire)                                    force_wr <= 1'b0;
      else if (scnt_inc && scnt + 4'd1 == STALL_LIM) force_wr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_meta_write_scheduler.sv
// Self-checking bench for meta_write_scheduler: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_meta_write_scheduler;

  localparam int IDX_W     = 6;
  localparam int WAYS      = 4;
  localparam int TAG_W     = 20;
  localparam int COH_W     = 2;
  localparam int STALL_MAX = 7;

  logic             clock;
  logic             reset;
  logic             in0_valid, in0_ready, in1_valid, in1_ready;
  logic [IDX_W-1:0] in0_idx, in1_idx, out_idx, lookup_idx;
  logic [WAYS-1:0]  in0_way_en, in1_way_en, out_way_en;
  logic [TAG_W-1:0] in0_tag, in1_tag, out_tag;
  logic [COH_W-1:0] in0_coh, in1_coh, out_coh;
  logic             rd_busy, out_valid, out_ready, out_src, force_wr, lookup_hit;

  meta_write_scheduler #(
    .IDX_W(IDX_W), .WAYS(WAYS), .TAG_W(TAG_W), .COH_W(COH_W), .STALL_MAX(STALL_MAX)
  ) dut (
    .clock(clock), .reset(reset),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_idx(in0_idx),
    .in0_way_en(in0_way_en), .in0_tag(in0_tag), .in0_coh(in0_coh),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_idx(in1_idx),
    .in1_way_en(in1_way_en), .in1_tag(in1_tag), .in1_coh(in1_coh),
    .rd_busy(rd_busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_way_en(out_way_en), .out_tag(out_tag), .out_coh(out_coh),
    .out_src(out_src), .force_wr(force_wr),
    .lookup_idx(lookup_idx), .lookup_hit(lookup_hit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [WAYS-1:0]  way_en;
    logic [TAG_W-1:0] tag;
    logic [COH_W-1:0] coh;
    logic             src;
  } ent_t;

  // Reference model: pending writes in arrival order, who is favoured next,
  // how many cycles the head has been held back by the read port, and the force flag.
  ent_t q[$];
  bit   favour1;
  int   held_back;
  bit   forcing;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    favour1   = 1'b0;
    held_back = 0;
    forcing   = 1'b0;
  endtask

  task automatic rand_in0();
    in0_idx = 6'($urandom_range(0, 7)); in0_way_en = 4'($urandom);
    in0_tag = 20'($urandom);            in0_coh    = 2'($urandom);
  endtask

  task automatic rand_in1();
    in1_idx = 6'($urandom_range(0, 7)); in1_way_en = 4'($urandom);
    in1_tag = 20'($urandom);            in1_coh    = 2'($urandom);
  endtask

  task automatic idle_inputs();
    in0_valid = 1'b0; in1_valid = 1'b0;
    rand_in0(); rand_in1();
  endtask

  // One clock cycle: inputs were set at the preceding falling edge.
  task automatic step();
    bit   take0, take1, pres, fired, hit;
    ent_t e;
    #1;
    take0 = 1'b0; take1 = 1'b0;
    if (q.size() < 2) begin
      if (in0_valid && in1_valid) begin
        take0 = !favour1; take1 = favour1;
      end else begin
        take0 = in0_valid; take1 = in1_valid;
      end
    end
    pres = (q.size() != 0) && (!rd_busy || forcing);
    hit  = 1'b0;
    foreach (q[i]) if (q[i].idx == lookup_idx) hit = 1'b1;

    check("in0_ready", in0_ready, take0);
    check("in1_ready", in1_ready, take1);
    check("out_valid", out_valid, pres);
    check("force_wr", force_wr, forcing);
    check("lookup_hit", lookup_hit, hit);
    if (q.size() != 0) begin
      check("out_idx", out_idx, q[0].idx);
      check("out_way_en", out_way_en, q[0].way_en);
      check("out_tag", out_tag, q[0].tag);
      check("out_coh", out_coh, q[0].coh);
      check("out_src", out_src, q[0].src);
    end

    if (take1) e = '{idx: in1_idx, way_en: in1_way_en, tag: in1_tag, coh: in1_coh, src: 1'b1};
    else       e = '{idx: in0_idx, way_en: in0_way_en, tag: in0_tag, coh: in0_coh, src: 1'b0};
    fired = pres && out_ready;

    @(posedge clock);
    if (fired) begin
      void'(q.pop_front());
      held_back = 0;
      forcing   = 1'b0;
    end else if (q.size() == 0) begin
      held_back = 0;
    end else if (rd_busy && !forcing) begin
      held_back++;
      if (held_back == STALL_MAX) forcing = 1'b1;
    end
    if (take0 || take1) begin
      q.push_back(e);
      favour1 = take0;
    end
    @(negedge clock);
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1'b1; rd_busy = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    rd_busy = 1'b0; out_ready = 1'b0; lookup_idx = '0;
    idle_inputs();
    #1 reset = 1'b0;
    in0_valid = 1'b1; in1_valid = 1'b1;
    #2;
    check("rst_in0_ready", in0_ready, 1'b0);
    check("rst_in1_ready", in1_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_force_wr", force_wr, 1'b0);
    check("rst_lookup_hit", lookup_hit, 1'b0);
    check("rst_out_tag", out_tag, '0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();

    // Both requesters streaming: grants alternate starting with in0.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_in0(); rand_in1();
      step();
    end
    check("alt_src_after_stream", out_src, 1'b1);

    // Back-pressure: two accepted, third waits until the first pop.
    drain();
    out_ready = 1'b0; in0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_in0();
      step();
    end
    check("full_blocks_in0", in0_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Bounded stall: head held back by rd_busy until force_wr.
    drain();
    in0_valid = 1'b1; rand_in0(); rd_busy = 1'b1;
    step();
    in0_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (force_wr) break;
      n++;
      step();
    end
    check("stall_cycles", n, STALL_MAX);
    step();
    check("force_clears_after_fire", force_wr, 1'b0);

    // Hazard lookup on a queued set index.
    drain();
    out_ready = 1'b0;
    in0_valid = 1'b1; rand_in0(); in0_idx = 6'h2A;
    step();
    in0_valid = 1'b0;
    lookup_idx = 6'h2A; #1;
    check("lookup_2a_hit", lookup_hit, 1'b1);
    lookup_idx = 6'h2B; #1;
    check("lookup_2b_miss", lookup_hit, 1'b0);
    out_ready = 1'b1;
    step();
    lookup_idx = 6'h2A; #1;
    check("lookup_after_fire", lookup_hit, 1'b0);
    @(negedge clock);

    // Asynchronous reset while full and forcing.
    out_ready = 1'b0; rd_busy = 1'b1; in0_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_in0();
      step();
    end
    for (int i = 0; i < 20; i++) begin
      if (force_wr) break;
      step();
    end
    check("force_before_reset", force_wr, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_force_wr", force_wr, 1'b0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in0_ready", in0_ready, 1'b0);
    check("arst_lookup_hit", lookup_hit, 1'b0);
    check("arst_out_idx", out_idx, '0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    rd_busy = 1'b0; in1_valid = 1'b1;
    step();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      in0_valid  = ($urandom_range(0, 9) < 7);
      in1_valid  = ($urandom_range(0, 9) < 7);
      rand_in0(); rand_in1();
      rd_busy    = ($urandom_range(0, 9) < 5);
      out_ready  = ($urandom_range(0, 9) < 7);
      lookup_idx = 6'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
